mii_rx_frame_ctrl: RTL

Receive frame controller for the MII datapath. Sits directly behind the MII nibble-to-byte assembler on `mii_clk`. It consumes the assembled byte stream and the raw `mii_en` envelope. It strips the preamble and SFD, forwards payload bytes with start/end-of-frame marks and an error flag, reports frame length, and keeps good/bad frame counters. It also drives the assembler's synchronous clear, which holds nibble alignment at reset and while discarding a bad frame.

---
 rtl/mii_rx_frame_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mii_rx_frame_ctrl.sv
// MII receive frame controller: takes assembled bytes plus the raw mii_en
// envelope, strips preamble/SFD, forwards payload bytes with sof/eof/err
// marks and a frame length, and keeps good/bad frame counters.
module mii_rx_frame_ctrl #(
  parameter int PRE_MIN = 2,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        mii_clk,
  input  logic        reset_n,
  input  logic        mii_en,
  input  logic        byte_rdy,
  input  logic [7:0]  byte_d,
  output logic        asm_clr,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_err,
  output logic [10:0] frame_len,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    PAY,
    DRAIN
  } state_t;

  localparam logic [10:0] MaxLen = 11'(MAX_LEN);
  localparam logic [10:0] MinLen = 11'(MIN_LEN);
  localparam logic [31:0] PreMin = 32'(PRE_MIN);

  state_t      state_q;
  logic        en_q;
  logic [2:0]  preCnt_q;
  logic [10:0] len_q;
  logic [7:0]  holdData_q;
  logic        holdFull_q;
  logic        first_q;

  logic        frameStart;
  logic        endCond;
  logic        preambleOk;
  logic        lenShort;

  // Frame boundaries: a frame only opens on a fresh rising edge of mii_en,
  // and closes when the envelope is low with no byte arriving alongside it.
  assign frameStart = mii_en & ~en_q;
  assign endCond    = ~mii_en & ~byte_rdy;
  assign preambleOk = {29'd0, preCnt_q} >= PreMin;
  assign lenShort   = len_q < MinLen;

  // Whole receive FSM with registered outputs. Payload bytes go through a
  // one-byte hold register so the last byte can be tagged with eof once the
  // end of the envelope is seen.
  always_ff @(posedge mii_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      en_q       <= 1'b1;
      preCnt_q   <= '0;
      len_q      <= '0;
      holdData_q <= '0;
      holdFull_q <= 1'b0;
      first_q    <= 1'b0;
      asm_clr    <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_err    <= 1'b0;
      frame_len  <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      en_q      <= mii_en;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;
      case (state_q)
        IDLE: begin
          asm_clr <= 1'b0;
          if (frameStart) begin
            preCnt_q <= '0;
            state_q  <= PRE;
          end
        end
        PRE: begin
          if (byte_rdy) begin
            if (byte_d == 8'h55) begin
              if (preCnt_q != 3'd7) preCnt_q <= preCnt_q + 3'd1;
            end else if (byte_d == 8'hD5 && preambleOk) begin
              len_q      <= '0;
              first_q    <= 1'b1;
              holdFull_q <= 1'b0;
              state_q    <= PAY;
            end else begin
              bad_cnt <= bad_cnt + 16'd1;
              asm_clr <= 1'b1;
              state_q <= DRAIN;
            end
          end else if (endCond) begin
            state_q <= IDLE;
          end
        end
        PAY: begin
          if (byte_rdy) begin
            if (len_q == MaxLen) begin
              out_valid  <= 1'b1;
              out_data   <= holdData_q;
              out_sof    <= first_q;
              out_eof    <= 1'b1;
              out_err    <= 1'b1;
              frame_len  <= MaxLen;
              first_q    <= 1'b0;
              holdFull_q <= 1'b0;
              bad_cnt    <= bad_cnt + 16'd1;
              asm_clr    <= 1'b1;
              state_q    <= DRAIN;
            end else begin
              if (holdFull_q) begin
                out_valid <= 1'b1;
                out_data  <= holdData_q;
                out_sof   <= first_q;
                first_q   <= 1'b0;
              end
              holdData_q <= byte_d;
              holdFull_q <= 1'b1;
              len_q      <= len_q + 11'd1;
            end
          end else if (endCond) begin
            if (holdFull_q) begin
              out_valid <= 1'b1;
              out_data  <= holdData_q;
              out_sof   <= first_q;
              out_eof   <= 1'b1;
              out_err   <= lenShort;
              frame_len <= len_q;
              first_q   <= 1'b0;
              if (lenShort) bad_cnt  <= bad_cnt + 16'd1;
              else          good_cnt <= good_cnt + 16'd1;
            end else begin
              bad_cnt <= bad_cnt + 16'd1;
            end
            holdFull_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        DRAIN: begin
          asm_clr <= 1'b1;
          if (!mii_en) begin
            asm_clr <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
